// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the register file and its write-pending scoreboard.
package reg_file_sb_pkg;
  localparam int unsigned REG_COUNT     = 16;
  localparam int unsigned REG_ADDR_BITS = 4;
  localparam logic [REG_ADDR_BITS-1:0] ZERO_REG = 4'd0;
endpackage

// File: rtl/reg_file_sb_mux16.sv
// 16:1 word multiplexer used by each register-file read port.
module mux16 #(
  parameter int unsigned BITS = 32
) (
  input  logic [15:0][BITS-1:0] d,
  input  logic [3:0]            sel,
  output logic [BITS-1:0]       y
);
  always_comb begin
    y = d[sel];
  end
endmodule

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register write-pending bits; an issue sets, a writeback clears, set wins.
import reg_file_sb_pkg::*;

module reg_scoreboard (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [REG_ADDR_BITS-1:0] issue_rd,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_BITS-1:0] wb_addr,
  output logic [REG_COUNT-1:0]     busy_mask
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_mask <= '0;
    end else begin
      busy_mask[0] <= 1'b0;
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        if (issue_valid && issue_rd == REG_ADDR_BITS'(i))
          busy_mask[i] <= 1'b1;
        else if (wb_valid && wb_addr == REG_ADDR_BITS'(i))
          busy_mask[i] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// 16-entry register file (r0 hardwired zero) with write-through bypass and
// hazard flags from the integrated scoreboard.
import reg_file_sb_pkg::*;

module reg_file_sb #(
  parameter int unsigned BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_ADDR_BITS-1:0] rs1_addr,
  input  logic [REG_ADDR_BITS-1:0] rs2_addr,
  output logic [BITS-1:0]          rs1_data,
  output logic [BITS-1:0]          rs2_data,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic                     issue_valid,
  input  logic [REG_ADDR_BITS-1:0] issue_rd,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_BITS-1:0] wb_addr,
  input  logic [BITS-1:0]          wb_data,
  output logic [REG_COUNT-1:0]     busy_mask
);
  logic [REG_COUNT-1:0][BITS-1:0] regs;
  logic [REG_COUNT-1:0]           wr_en;
  logic [BITS-1:0]                raw1, raw2;
  logic                           byp1, byp2;

  // One-hot write decode; bit 0 never enables so r0 stays zero.
  always_comb begin
    wr_en = '0;
    if (wb_valid && wb_addr != ZERO_REG)
      wr_en[wb_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 1; i < REG_COUNT; i++)
        if (wr_en[i]) regs[i] <= wb_data;
    end
  end

  mux16 #(.BITS(BITS)) u_mux_rs1 (.d(regs), .sel(rs1_addr), .y(raw1));
  mux16 #(.BITS(BITS)) u_mux_rs2 (.d(regs), .sel(rs2_addr), .y(raw2));

  reg_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .busy_mask   (busy_mask)
  );

  always_comb begin
    byp1 = wb_valid && (wb_addr == rs1_addr) && (rs1_addr != ZERO_REG);
    byp2 = wb_valid && (wb_addr == rs2_addr) && (rs2_addr != ZERO_REG);
    rs1_data = byp1 ? wb_data : raw1;
    rs2_data = byp2 ? wb_data : raw2;
    rs1_busy = busy_mask[rs1_addr] && !byp1;
    rs2_busy = busy_mask[rs2_addr] && !byp2;
  end
endmodule
